uart_frame_injector: RTL and testbench

- APB-programmed UART transmitter for the verification environment. It drives the serial net (uart_0to1 / uart_1to0 style) that the UART protocol checker monitors.
- Software configures frame format and baud, pushes bytes into a small FIFO, and can force a single parity or framing error into the next frame.
- Serves as the stimulus/peer end for receivers and protocol checkers; lives in the checker/env RTL area.

---
 rtl/uart_frame_injector.sv | 230 +++++++++++++++++++++++
 tb/tb_uart_frame_injector.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_injector.sv
// APB-programmed UART transmitter that drives a serial net for receivers and protocol checkers.
// Software sets the frame format and baud, queues bytes, and can corrupt the parity or stop bits of one frame.
module uart_frame_injector #(
  parameter int          FIFO_DEPTH = 4,
  parameter int          ADDR_W     = 12,
  parameter logic [15:0] DIV_RST    = 16'd15
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [31:0]       pwdata,
  input  logic [3:0]        pstrb,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  output logic              uart_net,
  output logic              tx_busy
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // APB: an access is psel & penable; zero wait states, registers update on the access edge.
  state_t           r_state;
  state_t           w_next;

  logic [7:0]       r_ctrl;
  logic [15:0]      r_baud;

  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic [1:0]       r_f_bits;
  logic             r_f_par_en;
  logic             r_f_two_stop;
  logic             r_f_inj_frm;
  logic             r_par_bit;
  logic [15:0]      r_f_div;
  logic [15:0]      r_baud_cnt;
  logic [7:0]       r_shift;
  logic [2:0]       r_bit_cnt;
  logic             r_stop_cnt;

  logic             w_access;
  logic             w_wr;
  logic             w_addr_ok;
  logic             w_sel_ctrl;
  logic             w_sel_baud;
  logic             w_sel_tx;
  logic             w_sel_stat;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_start_ok;
  logic             w_frame_start;
  logic             w_tick;
  logic             w_last_data;
  logic             w_last_stop;
  logic [7:0]       w_head;
  logic [7:0]       w_mask;
  logic [4:0]       w_cnt5;
  logic             w_unused;

  assign w_access   = psel & penable;
  assign w_wr       = w_access & pwrite;
  assign w_addr_ok  = (paddr[ADDR_W-1:4] == '0);
  assign w_sel_ctrl = w_addr_ok && (paddr[3:2] == 2'd0);
  assign w_sel_baud = w_addr_ok && (paddr[3:2] == 2'd1);
  assign w_sel_tx   = w_addr_ok && (paddr[3:2] == 2'd2);
  assign w_sel_stat = w_addr_ok && (paddr[3:2] == 2'd3);

  assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);
  // Full is the registered value, so a push is refused even if a pop happens on the same edge.
  assign w_push  = w_wr && w_sel_tx && pstrb[0] && !w_full;
  assign w_cnt5  = 5'(r_count);

  assign pready  = 1'b1;
  assign pslverr = w_access && (!w_addr_ok || (pwrite && w_sel_stat) ||
                                (pwrite && w_sel_tx && w_full));

  assign w_unused = &{1'b0, pwdata[31:16], paddr[1:0], pstrb[3:2]};

  always_comb begin
    prdata = '0;
    if (psel && !pwrite) begin
      if (w_sel_ctrl) prdata[7:0]  = r_ctrl;
      if (w_sel_baud) prdata[15:0] = r_baud;
      if (w_sel_stat) prdata[7:0]  = {w_cnt5, w_full, w_empty, tx_busy};
    end
  end

  // Inject bits are one-shot: cleared when a frame latches them unless software writes CTRL on that edge.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_ctrl <= '0;
      r_baud <= DIV_RST;
    end else begin
      if (w_wr && w_sel_ctrl && pstrb[0]) begin
        r_ctrl <= pwdata[7:0];
      end else if (w_frame_start) begin
        r_ctrl[7:6] <= 2'b00;
      end
      if (w_wr && w_sel_baud) begin
        if (pstrb[0]) r_baud[7:0]  <= pwdata[7:0];
        if (pstrb[1]) r_baud[15:8] <= pwdata[15:8];
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (w_push) r_mem[r_wr_ptr] <= pwdata[7:0];
  end

  assign w_head = r_mem[r_rd_ptr];

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push)        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_frame_start) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_frame_start);
    end
  end

  assign w_start_ok    = r_ctrl[0] && !w_empty;
  assign w_tick        = (r_baud_cnt == 16'd0);
  assign w_last_data   = (r_bit_cnt == (3'd4 + {1'b0, r_f_bits}));
  assign w_last_stop   = (r_stop_cnt == r_f_two_stop);
  assign w_frame_start = ((r_state == S_IDLE) && w_start_ok) ||
                         ((r_state == S_STOP) && w_tick && w_last_stop && w_start_ok);

  always_comb begin
    w_mask = 8'hFF;
    case (r_ctrl[2:1])
      2'd0:    w_mask = 8'h1F;
      2'd1:    w_mask = 8'h3F;
      2'd2:    w_mask = 8'h7F;
      default: w_mask = 8'hFF;
    endcase
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_start_ok) w_next = S_START;
      S_START:  if (w_tick) w_next = S_DATA;
      S_DATA:   if (w_tick && w_last_data) w_next = r_f_par_en ? S_PARITY : S_STOP;
      S_PARITY: if (w_tick) w_next = S_STOP;
      S_STOP:   if (w_tick && w_last_stop) w_next = w_start_ok ? S_START : S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // The whole frame format, parity bit and divider are captured at the pop so mid-frame writes wait a frame.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_f_bits     <= '0;
      r_f_par_en   <= 1'b0;
      r_f_two_stop <= 1'b0;
      r_f_inj_frm  <= 1'b0;
      r_par_bit    <= 1'b0;
      r_f_div      <= '0;
      r_baud_cnt   <= '0;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_stop_cnt   <= 1'b0;
    end else if (w_frame_start) begin
      r_f_bits     <= r_ctrl[2:1];
      r_f_par_en   <= r_ctrl[3];
      r_f_two_stop <= r_ctrl[5];
      r_f_inj_frm  <= r_ctrl[7];
      r_par_bit    <= (^(w_head & w_mask)) ^ r_ctrl[4] ^ r_ctrl[6];
      r_f_div      <= r_baud;
      r_baud_cnt   <= r_baud;
      r_shift      <= w_head;
      r_bit_cnt    <= '0;
      r_stop_cnt   <= 1'b0;
    end else if (r_state != S_IDLE) begin
      if (w_tick) begin
        r_baud_cnt <= r_f_div;
        if (r_state == S_DATA) begin
          r_shift   <= r_shift >> 1;
          r_bit_cnt <= r_bit_cnt + 3'd1;
        end
        if (r_state == S_STOP) r_stop_cnt <= ~r_stop_cnt;
      end else begin
        r_baud_cnt <= r_baud_cnt - 16'd1;
      end
    end
  end

  always_comb begin
    uart_net = 1'b1;
    tx_busy  = 1'b1;
    case (r_state)
      S_IDLE:   tx_busy  = 1'b0;
      S_START:  uart_net = 1'b0;
      S_DATA:   uart_net = r_shift[0];
      S_PARITY: uart_net = r_par_bit;
      S_STOP:   uart_net = ~r_f_inj_frm;
      default:  tx_busy  = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_uart_frame_injector.sv
// Bench for uart_frame_injector: register vectors, hand-built frame sequences and randomized bursts
// checked against a bit-list model of the serial frame.
module tb_uart_frame_injector;

  localparam int FIFO_DEPTH = 4;
  localparam logic [11:0] A_CTRL = 12'h000;
  localparam logic [11:0] A_BAUD = 12'h004;
  localparam logic [11:0] A_TX   = 12'h008;
  localparam logic [11:0] A_STAT = 12'h00C;

  logic        pclk = 1'b0;
  logic        preset;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic        uart_net;
  logic        tx_busy;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  exp_q[$];

  typedef struct {
    logic        wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic        exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[$];

  uart_frame_injector #(.FIFO_DEPTH(FIFO_DEPTH), .ADDR_W(12), .DIV_RST(16'd15)) dut (
    .pclk(pclk), .preset(preset), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready),
    .pslverr(pslverr), .uart_net(uart_net), .tx_busy(tx_busy)
  );

  always #5 pclk = ~pclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apb_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic err);
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d; pstrb = s;
    @(negedge pclk);
    penable = 1'b1;
    #1 err = pslverr;
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; pstrb = 4'h0;
  endtask

  task automatic apb_read(input logic [11:0] a, output logic [31:0] d, output logic err);
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a; pstrb = 4'h0;
    @(negedge pclk);
    penable = 1'b1;
    #1 begin d = prdata; err = pslverr; end
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0;
  endtask

  // Reference frame: start 0, n data bits LSB first, optional parity, 1 or 2 stop bits.
  function automatic int build_frame(input logic [7:0] data, input logic [7:0] ctrl,
                                     output logic [11:0] bits);
    int n, ones, idx;
    logic p;
    bits = '0;
    n    = int'(ctrl[2:1]) + 5;
    ones = 0;
    idx  = 0;
    bits[idx] = 1'b0; idx++;
    for (int i = 0; i < n; i++) begin
      bits[idx] = data[i]; idx++;
      ones += int'(data[i]);
    end
    if (ctrl[3]) begin
      p = (ones % 2) == 1;
      if (ctrl[4]) p = !p;
      if (ctrl[6]) p = !p;
      bits[idx] = p; idx++;
    end
    for (int s = 0; s < (ctrl[5] ? 2 : 1); s++) begin
      bits[idx] = ctrl[7] ? 1'b0 : 1'b1; idx++;
    end
    return idx;
  endfunction

  // Starts sampling at the next falling edge, which must be the first cycle of the start bit.
  task automatic check_frame(input logic [7:0] data, input logic [7:0] ctrl, input logic [15:0] div);
    logic [11:0] bits;
    int len;
    int busy_low;
    busy_low = 0;
    len = build_frame(data, ctrl, bits);
    for (int i = 0; i < len; i++) begin
      logic [31:0] obs;
      logic [31:0] expv;
      obs  = '0;
      expv = '0;
      for (int c = 0; c <= int'(div); c++) begin
        @(negedge pclk);
        obs[c]  = uart_net;
        expv[c] = bits[i];
        if (tx_busy !== 1'b1) busy_low++;
      end
      chk($sformatf("frame %02h ctrl %02h bit %0d line", data, ctrl, i), obs, expv);
    end
    chk($sformatf("frame %02h busy-low cycles", data), busy_low, 0);
  endtask

  task automatic run_burst(input logic [7:0] ctrl, input logic [15:0] div, input int nbytes,
                           input logic [7:0] first);
    logic        err;
    logic [31:0] rd;
    logic [7:0]  d;
    logic [7:0]  cur;
    logic        exp_err;
    int          sz;
    apb_write(A_BAUD, {16'h0, div}, 4'b0011, err);
    apb_write(A_CTRL, {24'h0, ctrl & 8'hFE}, 4'b0001, err);
    for (int k = 0; k < nbytes; k++) begin
      d = (k == 0) ? first : 8'($urandom);
      exp_err = (exp_q.size() >= FIFO_DEPTH);
      apb_write(A_TX, {24'h0, d}, 4'b0001, err);
      chk($sformatf("push %0d pslverr", k), err, exp_err);
      if (!exp_err) exp_q.push_back(d);
    end
    sz = exp_q.size();
    apb_read(A_STAT, rd, err);
    chk("status after loading", rd, (sz << 3) | ((sz == FIFO_DEPTH) ? 4 : 0) | ((sz == 0) ? 2 : 0));
    cur = ctrl | 8'h01;
    apb_write(A_CTRL, {24'h0, cur}, 4'b0001, err);
    while (exp_q.size() > 0) begin
      d = exp_q.pop_front();
      check_frame(d, cur, div);
      cur[7:6] = 2'b00;
    end
    @(negedge pclk);
    chk("idle after burst {busy,net}", {tx_busy, uart_net}, 2'b01);
    apb_read(A_CTRL, rd, err);
    chk("ctrl after burst", rd, {24'h0, cur});
    apb_read(A_STAT, rd, err);
    chk("status after burst", rd, 32'h02);
    apb_write(A_CTRL, 32'h0, 4'b0001, err);
  endtask

  logic [31:0] rd;
  logic        err;
  logic [9:0]  pat;
  logic [39:0] obs40;
  logic [39:0] exp40;
  int          bad;

  initial begin
    preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0;
    repeat (2) @(negedge pclk);
    chk("reset uart_net", uart_net, 1'b1);
    chk("reset tx_busy", tx_busy, 1'b0);
    chk("reset prdata", prdata, 32'h0);
    chk("reset pslverr", pslverr, 1'b0);
    chk("pready", pready, 1'b1);
    preset = 1'b0;

    vecs.push_back('{1'b0, A_CTRL, 32'h0,        4'h0, 1'b0, 32'h0});
    vecs.push_back('{1'b0, A_BAUD, 32'h0,        4'h0, 1'b0, 32'h0000000F});
    vecs.push_back('{1'b0, A_STAT, 32'h0,        4'h0, 1'b0, 32'h02});
    vecs.push_back('{1'b0, 12'h010, 32'h0,       4'h0, 1'b1, 32'h0});
    vecs.push_back('{1'b1, A_STAT, 32'hFF,       4'hF, 1'b1, 32'h0});
    vecs.push_back('{1'b1, 12'h014, 32'h1,       4'hF, 1'b1, 32'h0});
    vecs.push_back('{1'b1, A_BAUD, 32'h1200,     4'b0010, 1'b0, 32'h0});
    vecs.push_back('{1'b0, A_BAUD, 32'h0,        4'h0, 1'b0, 32'h120F});
    vecs.push_back('{1'b1, A_BAUD, 32'hFFAB,     4'b0001, 1'b0, 32'h0});
    vecs.push_back('{1'b0, A_BAUD, 32'h0,        4'h0, 1'b0, 32'h12AB});
    vecs.push_back('{1'b1, A_CTRL, 32'h3E,       4'b0000, 1'b0, 32'h0});
    vecs.push_back('{1'b0, A_CTRL, 32'h0,        4'h0, 1'b0, 32'h0});
    vecs.push_back('{1'b1, A_CTRL, 32'hFFFFFF36, 4'hF, 1'b0, 32'h0});
    vecs.push_back('{1'b0, A_CTRL, 32'h0,        4'h0, 1'b0, 32'h36});
    vecs.push_back('{1'b0, A_TX,   32'h0,        4'h0, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 12'h100, 32'h0,       4'h0, 1'b1, 32'h0});
    vecs.push_back('{1'b1, A_TX,   32'hAA,       4'b1110, 1'b0, 32'h0});
    vecs.push_back('{1'b0, A_STAT, 32'h0,        4'h0, 1'b0, 32'h02});
    vecs.push_back('{1'b1, A_CTRL, 32'h0,        4'h1, 1'b0, 32'h0});
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].wr) begin
        apb_write(vecs[i].addr, vecs[i].wdata, vecs[i].strb, err);
        chk($sformatf("vec %0d write pslverr", i), err, vecs[i].exp_err);
      end else begin
        apb_read(vecs[i].addr, rd, err);
        chk($sformatf("vec %0d read pslverr", i), err, vecs[i].exp_err);
        chk($sformatf("vec %0d prdata", i), rd, vecs[i].exp_rd);
      end
    end

    // 8N1, div 3: TXDATA push lands in an idle enabled FIFO, start bit begins one edge later.
    apb_write(A_BAUD, 32'h3, 4'b0011, err);
    apb_write(A_CTRL, 32'h07, 4'b0001, err);
    apb_write(A_TX, 32'hA5, 4'b0001, err);
    pat = 10'h34A;
    for (int i = 0; i < 40; i++) begin
      @(negedge pclk);
      obs40[i] = uart_net;
      exp40[i] = pat[i / 4];
    end
    chk("8N1 A5 waveform", obs40, exp40);
    @(negedge pclk);
    chk("8N1 busy after stop", tx_busy, 1'b0);
    apb_write(A_CTRL, 32'h0, 4'b0001, err);

    run_burst(8'h0F, 16'd3, 1, 8'hA5);
    run_burst(8'h1F, 16'd3, 1, 8'hA5);
    run_burst(8'h25, 16'd2, 1, 8'h7F);

    // One-shot parity and framing error, then a clean back-to-back frame.
    apb_write(A_BAUD, 32'h3, 4'b0011, err);
    apb_write(A_CTRL, 32'hCF, 4'b0001, err);
    apb_write(A_TX, 32'h01, 4'b0001, err);
    fork
      begin
        check_frame(8'h01, 8'hCF, 16'd3);
        check_frame(8'h01, 8'h0F, 16'd3);
      end
      begin
        apb_read(A_CTRL, rd, err);
        chk("ctrl inject self-clear", rd, 32'h0F);
        apb_write(A_TX, 32'h01, 4'b0001, err);
        chk("push during frame pslverr", err, 1'b0);
      end
    join
    @(negedge pclk);
    chk("idle after inject pair", {tx_busy, uart_net}, 2'b01);
    apb_write(A_CTRL, 32'h0, 4'b0001, err);

    run_burst(8'h07, 16'd1, 5, 8'h5A);

    // Clearing en and changing div mid-frame: current frame unaffected, no further pop.
    apb_write(A_BAUD, 32'h3, 4'b0011, err);
    apb_write(A_CTRL, 32'h06, 4'b0001, err);
    apb_write(A_TX, 32'h3C, 4'b0001, err);
    apb_write(A_TX, 32'hC3, 4'b0001, err);
    apb_write(A_CTRL, 32'h07, 4'b0001, err);
    fork
      check_frame(8'h3C, 8'h07, 16'd3);
      begin
        apb_write(A_BAUD, 32'h1, 4'b0011, err);
        apb_write(A_CTRL, 32'h06, 4'b0001, err);
      end
    join
    bad = 0;
    repeat (8) begin
      @(negedge pclk);
      if ({tx_busy, uart_net} !== 2'b01) bad++;
    end
    chk("no pop after en cleared", bad, 0);
    apb_read(A_STAT, rd, err);
    chk("status one left", rd, 32'h08);
    apb_write(A_CTRL, 32'h07, 4'b0001, err);
    check_frame(8'hC3, 8'h07, 16'd1);
    @(negedge pclk);
    chk("idle after new-div frame", {tx_busy, uart_net}, 2'b01);
    apb_write(A_CTRL, 32'h0, 4'b0001, err);

    for (int it = 0; it < 6; it++) begin
      run_burst(8'($urandom_range(0, 255)), 16'($urandom_range(0, 4)),
                int'($urandom_range(1, 6)), 8'($urandom));
    end

    // Asynchronous reset in the middle of a frame.
    apb_write(A_BAUD, 32'h3, 4'b0011, err);
    apb_write(A_CTRL, 32'h07, 4'b0001, err);
    apb_write(A_TX, 32'h00, 4'b0001, err);
    repeat (6) @(negedge pclk);
    chk("pre-reset in data {busy,net}", {tx_busy, uart_net}, 2'b10);
    #2 preset = 1'b1;
    #1 chk("async reset {busy,net}", {tx_busy, uart_net}, 2'b01);
    @(negedge pclk);
    preset = 1'b0;
    apb_read(A_STAT, rd, err);
    chk("status after reset", rd, 32'h02);
    apb_read(A_CTRL, rd, err);
    chk("ctrl after reset", rd, 32'h0);
    apb_read(A_BAUD, rd, err);
    chk("baud after reset", rd, 32'h0F);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
